// File: rtl/ps2_pkg.sv
// ============================================================================
// ps2_pkg : shared PS/2 types and constants (host transmitter, receiver)
// Revision: 1.0
// ============================================================================
`default_nettype none

package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    SHIFT     = 3'd3,
    WAIT_ACK  = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

  // Device clock falling edges from start bit to released stop bit
  localparam logic [3:0] PS2_FRAME_EDGES  = 4'd10;

endpackage

`default_nettype wire

// File: rtl/ps2_sync_edge.sv
// ============================================================================
// ps2_sync_edge : 2-FF synchronizer plus falling-edge detect for one PS/2 pin
// Revision: 1.0
// ============================================================================
`default_nettype none

module ps2_sync_edge
  import ps2_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic pin_async,
  output logic level,
  output logic fall
);

  // [0],[1] synchronize; [2] holds the previous synchronized level
  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], pin_async};
  end

  // Idle PS/2 lines are high, so reset to 1 to avoid a spurious edge
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign level = sync_q[1];
  assign fall  = sync_q[2] & ~sync_q[1];

endmodule

`default_nettype wire

// File: rtl/ps2_host_tx.sv
// ============================================================================
// ps2_host_tx : PS/2 host-to-device command transmitter (open-drain enables)
// Optional watchdog enabled by defining PS2_TX_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err
);

  // One counter serves the inhibit phase and, when enabled, the watchdog
  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  logic clk_level, clk_fall;
  logic data_level, data_fall_unused;

  ps2_sync_edge u_sync_clk (
    .clk       (clk),
    .resetn    (resetn),
    .pin_async (ps2_clk),
    .level     (clk_level),
    .fall      (clk_fall)
  );

  ps2_sync_edge u_sync_data (
    .clk       (clk),
    .resetn    (resetn),
    .pin_async (ps2_data),
    .level     (data_level),
    .fall      (data_fall_unused)
  );

  ps2_tx_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [8:0]       frame_q, frame_d;
  logic             clk_dl_q, clk_dl_d;
  logic             data_dl_q, data_dl_d;
  logic             done_q, done_d;
  logic             ack_err_q, ack_err_d;
  logic             timeout_err_q, timeout_err_d;
  logic             nack_q, nack_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_cnt_d     = bit_cnt_q;
    frame_d       = frame_q;
    clk_dl_d      = clk_dl_q;
    data_dl_d     = data_dl_q;
    done_d        = 1'b0;
    ack_err_d     = 1'b0;
    timeout_err_d = 1'b0;
    nack_d        = nack_q;

    // done is registered, so the return to IDLE follows one cycle after it
    if (done_q) begin
      state_d   = IDLE;
      clk_dl_d  = 1'b0;
      data_dl_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          clk_dl_d  = 1'b0;
          data_dl_d = 1'b0;
          if (tx_valid) begin
            frame_d  = {~^tx_data, tx_data};
            nack_d   = 1'b0;
            cnt_d    = '0;
            clk_dl_d = 1'b1;
            state_d  = INHIBIT;
          end
        end
        INHIBIT: begin
          if (cnt_q == INH_LAST) begin
            clk_dl_d  = 1'b0;
            data_dl_d = 1'b1;
            bit_cnt_d = 4'd0;
            cnt_d     = '0;
            state_d   = REQ;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        REQ: begin
          state_d = SHIFT;
        end
        SHIFT: begin
          if (clk_fall) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_d == PS2_FRAME_EDGES) begin
              data_dl_d = 1'b0;
              state_d   = WAIT_ACK;
            end else begin
              data_dl_d = ~frame_q[bit_cnt_q];
            end
          end
        end
        WAIT_ACK: begin
          if (clk_fall) begin
            nack_d  = data_level;
            state_d = WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (clk_level && data_level) begin
            done_d    = 1'b1;
            ack_err_d = nack_q;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

`ifdef PS2_TX_TIMEOUT_EN
      if (state_q inside {REQ, SHIFT, WAIT_ACK, WAIT_IDLE}) begin
        if (clk_fall || (state_d != state_q)) begin
          cnt_d = '0;
        end else if (cnt_q == TO_LAST) begin
          clk_dl_d      = 1'b0;
          data_dl_d     = 1'b0;
          done_d        = 1'b1;
          ack_err_d     = 1'b0;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_cnt_q     <= 4'd0;
      frame_q       <= 9'd0;
      clk_dl_q      <= 1'b0;
      data_dl_q     <= 1'b0;
      done_q        <= 1'b0;
      ack_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      nack_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      frame_q       <= frame_d;
      clk_dl_q      <= clk_dl_d;
      data_dl_q     <= data_dl_d;
      done_q        <= done_d;
      ack_err_q     <= ack_err_d;
      timeout_err_q <= timeout_err_d;
      nack_q        <= nack_d;
    end
  end

  assign tx_ready           = (state_q == IDLE);
  assign busy               = (state_q != IDLE);
  assign ps2_clk_drive_low  = clk_dl_q;
  assign ps2_data_drive_low = data_dl_q;
  assign done               = done_q;
  assign ack_err            = ack_err_q;
  assign timeout_err        = timeout_err_q;

endmodule

`default_nettype wire

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte, such as 0xED (set LEDs) or 0xFF (reset), from the FPGA host to the keyboard using the PS/2 host-to-device request protocol. It drives both open-drain lines through drive-low enables and samples the same pins back. It sits beside `ps2_keyboard` on the shared `ps2_clk`/`ps2_data` pins, and its `busy` output gates the receiver while a transmission is in progress.

## Interface
- `INHIBIT_CYCLES`, default 5000: clk cycles `ps2_clk` is held low before the request (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, default 1_000_000: watchdog limit, in clk cycles, between device clock falling edges. Used only with `PS2_TX_TIMEOUT_EN`.
- `clk`  in  1: system clock.
- `resetn`  in  1: reset, asynchronous and active-low.
- `tx_valid`  in  1: request to send `tx_data`.
- `tx_data`  in  8: command byte. Captured at handshake.
- `tx_ready`  out  1: block is idle and can accept a byte.
- `ps2_clk`  in  1: raw PS/2 clock pin level (asynchronous).
- `ps2_data`  in  1: raw PS/2 data pin level (asynchronous).
- `ps2_clk_drive_low`  out  1: 1 = pull the clock line low; 0 = release it.
- `ps2_data_drive_low`  out  1: 1 = pull the data line low; 0 = release it.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when a transfer ends, whatever the outcome.
- `ack_err`  out  1: one-cycle pulse with `done` when the device did not acknowledge.
- `timeout_err`  out  1: one-cycle pulse with `done` when the watchdog aborted the transfer.

## Operation
- Input conditioning: `ps2_clk` and `ps2_data` each pass through a 2-FF synchronizer. A third register on the clock gives `fall = prev & ~cur`.
- Handshake: a byte is accepted when `tx_valid & tx_ready`. `tx_ready` = (state == IDLE). `tx_valid` while busy is ignored.
- At accept, the frame is latched: `tx_data` plus `parity = ~^tx_data` (odd parity).
- States and transitions:
  - IDLE: both lines released. On accept → INHIBIT, counter cleared.
  - INHIBIT: `ps2_clk_drive_low`=1 for exactly `INHIBIT_CYCLES` cycles, then → REQ. Falling edges are ignored in this state.
  - REQ: `ps2_data_drive_low`=1 (start bit) and the clock line is released. Bit counter is 0. → SHIFT.
  - SHIFT: on each `fall` the counter increments and the data line is updated:
    - edges 1–8: `ps2_data_drive_low` = ~data[edge-1], LSB first.
    - edge 9: `ps2_data_drive_low` = ~parity.
    - edge 10: data line released (stop bit = 1).
    - After edge 10 → WAIT_ACK.
  - WAIT_ACK: on the next `fall`, sample synchronized `ps2_data`. 0 = ACK; 1 = set the `ack_err` flag. → WAIT_IDLE.
  - WAIT_IDLE: wait until synchronized clock and data are both 1. Then pulse `done` (plus `ack_err` if the flag is set) → IDLE.
- The bit counter is 4 bits and counts edges 0–10. It is cleared on entry to REQ and never wraps.
- Reset, including mid-transfer: all outputs immediately go to their reset values, which releases both lines. Reset values: `tx_ready`=1; `busy`, `done`, `ack_err`, `timeout_err` = 0; `ps2_clk_drive_low` = `ps2_data_drive_low` = 0.

## Timing
- All outputs are registered, except `tx_ready` and `busy`, which decode the state register.
- Accept in cycle N puts `ps2_clk_drive_low` high in cycle N+1. It falls in cycle N+1+`INHIBIT_CYCLES`, the same cycle `ps2_data_drive_low` rises.
- From a raw pin falling edge to the data-line update takes 3 clk cycles (2 sync + edge register). This is well inside the device's roughly 30 µs low phase.
- `done` and the error pulses last exactly 1 cycle. `tx_ready` returns in the cycle after `done`, so back-to-back transfers are possible.

## Configuration
- `PS2_TX_TIMEOUT_EN` defined:
  - A watchdog counter clears on every `fall` and on every state change. It runs in REQ, SHIFT, WAIT_ACK and WAIT_IDLE.
  - When it reaches `TIMEOUT_CYCLES`, both lines are released, `done` and `timeout_err` pulse together, and the block goes to IDLE the next cycle.
- `PS2_TX_TIMEOUT_EN` undefined: no watchdog. `timeout_err` is tied to 0, and a stalled device hangs the block until reset.

## Structure
- Package `ps2_pkg` holds:
  - the state enum (IDLE, INHIBIT, REQ, SHIFT, WAIT_ACK, WAIT_IDLE);
  - command constants `PS2_CMD_SET_LEDS`=8'hED, `PS2_CMD_ECHO`=8'hEE, `PS2_CMD_RESET`=8'hFF;
  - response constant `PS2_RSP_ACK`=8'hFA;
  - `PS2_FRAME_EDGES`=10.
- Sub-module `ps2_sync_edge`: 2-FF synchronizer plus falling-edge detect. One instance per pin, and reusable by the receiver.

## Test plan
Bench: PS/2 device model clocking at 12.5 kHz. Overrides: `INHIBIT_CYCLES`=50, `TIMEOUT_CYCLES`=2000.
- Inhibit timing: accept 0xFF → `ps2_clk_drive_low` high for exactly 50 cycles; `ps2_data_drive_low` rises in the cycle the clock is released.
- 0xED with device ACK → device samples start 0; data bits 1,0,1,1,0,1,1,1; parity 1; stop 1. Then `done`=1 for 1 cycle, with `ack_err`=0 and `timeout_err`=0.
- 0x07 → parity bit sampled as 0. 0x00 → parity bit 1.
- Device holds data high on the ACK edge → `done` and `ack_err` pulse together; `tx_ready` is 1 next cycle.
- Device stops clocking after 4 bits, with the macro defined → after 2000 cycles both drive-lows are 0 and `done` and `timeout_err` pulse. Without the macro, `busy` stays 1.
- Reset asserted mid-SHIFT → both drive-lows are 0 in the same cycle. Also: a second `tx_valid` asserted during INHIBIT is ignored, with no second frame on the wire.
